alu_result_decoder: RTL and testbench
=====================================

ALU_RESULT_DECODER -- requirements
Module: alu_result_decoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  y_in carries a valid result word this cycle.
REQ-004 y_in  input  4  result word, frame order ADD, SUB, AND, OR.
REQ-005 resync  input  1  force frame phase back to ADD.
REQ-006 a_out  output  3  recovered operand A.
REQ-007 b_out  output  3  recovered operand B.
REQ-008 out_valid  output  1  one-cycle pulse; a_out/b_out/err valid.
REQ-009 err  output  1  frame inconsistency flag, qualified by out_valid.
REQ-010 err_sticky  output  1  set on any err pulse; cleared only by reset.
REQ-011 phase  output  2  expected type of next word: 0 ADD, 1 SUB, 2 AND, 3 OR.

Function
REQ-012 Phase counter SHALL advance by one, wrapping 3->0, only on cycles with in_valid=1.
REQ-013 Word-type encoding: ADD y_in={carry,(A+B)[2:0]}; SUB y_in={borrow,(A-B) mod 8}, i.e. 4-bit two's complement of A-B; AND y_in={0,A&B}; OR y_in={0,A|B}.
REQ-014 Decoder SHALL capture S (ADD word, unsigned 0..15) and D (SUB word, signed -8..7) into registers at their phases.
REQ-015 Recovery: A=(S+D)/2, B=(S-D)/2, computed at 6-bit signed width without overflow.
REQ-016 Arithmetic error: S[0]!=D[0], or recovered A or B outside 0..7.
REQ-017 On acceptance of the OR-phase word, out_valid SHALL pulse high the next cycle with a_out, b_out, err registered; latency 1 cycle after the fourth word.
REQ-018 a_out/b_out SHALL hold their last values between frames; out_valid is high for exactly one cycle per completed frame.
REQ-019 resync=1 SHALL discard any partial frame; if in_valid=1 in the same cycle, that word is taken as the ADD word and phase becomes 1, else phase becomes 0.
REQ-020 Gaps (in_valid=0) at any point mid-frame SHALL not alter captured data or phase.
REQ-021 err and err_sticky are flags only; decoding continues normally after an error.

Reset
REQ-022 On reset=1 at a clock edge: phase=0, out_valid=0, err=0, err_sticky=0, a_out=0, b_out=0, captured S/D cleared; reset overrides resync and in_valid.
REQ-023 Reset mid-frame SHALL discard the partial frame; no out_valid for it.

Configuration
REQ-024 Macro ALU_RESULT_LOGIC_CHECK_EN defined: err additionally SET when AND word != {0,A&B} or OR word != {0,A|B}, using recovered A, B; AND word captured at phase 2.
REQ-025 Macro undefined: AND/OR words consume phases but their values are ignored; err reflects REQ-016 only; no AND-capture register.

Structure
REQ-026 Package alu_frame_pkg SHALL hold OPW=3, RESW=4, phase enumeration PH_ADD/PH_SUB/PH_AND/PH_OR.
REQ-027 One combinational sub-module operand_solver: inputs S, D; outputs A, B, arith_err.

Verification
REQ-028 A=5,B=3 frame 1000,0010,0001,0111 -> out_valid one cycle later, a_out=5, b_out=3, err=0.
REQ-029 A=2,B=6 frame 1000,1100,0010,0110 -> a_out=2, b_out=6, err=0.
REQ-030 Frame 0111,0010,0000,0000 (parity mismatch) -> err=1, err_sticky stays 1 across later clean frames.
REQ-031 With macro: frame 1000,0010,0011,0111 -> err=1; without macro -> err=0, a_out=5, b_out=3.
REQ-032 Reset after two words, then full A=5,B=3 frame -> no out_valid until that frame completes, then a_out=5, b_out=3.
REQ-033 resync+in_valid with 1000 after one stray word, then 0010,0001,0111 with gaps -> a_out=5, b_out=3, err=0.

Source files
------------

// File: rtl/alu_frame_pkg.sv
// alu_frame_pkg
// Shared widths and frame-phase definitions for the ALU result decoder.
// A frame is four result words in fixed order: ADD, SUB, AND, OR.
// Optional build macro used by the decoder: ALU_RESULT_LOGIC_CHECK_EN.
package alu_frame_pkg;

    localparam int unsigned OPW  = 3;   // operand width
    localparam int unsigned RESW = 4;   // result word width

    typedef enum logic [1:0] {
        PH_ADD = 2'd0,
        PH_SUB = 2'd1,
        PH_AND = 2'd2,
        PH_OR  = 2'd3
    } phase_t;

    // Frame order with wrap from OR back to ADD.
    function automatic phase_t phase_next(input phase_t p);
        phase_t n;
        case (p)
            PH_ADD:  n = PH_SUB;
            PH_SUB:  n = PH_AND;
            PH_AND:  n = PH_OR;
            default: n = PH_ADD;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_result_decoder_operand_solver.sv
// operand_solver
// Combinational recovery of operands A and B from the ADD word S
// (unsigned 0..15) and the SUB word D (signed -8..7).
// Ports:
//   s         in  RESW  ADD word {carry, sum[2:0]}
//   d         in  RESW  SUB word, two's complement of A-B
//   a         out OPW   recovered A = (S+D)/2
//   b         out OPW   recovered B = (S-D)/2
//   arith_err out 1     parity mismatch or A/B outside 0..7
module operand_solver
    import alu_frame_pkg::*;
(
    input  logic [RESW-1:0] s,
    input  logic [RESW-1:0] d,
    output logic [OPW-1:0]  a,
    output logic [OPW-1:0]  b,
    output logic            arith_err
);

    // 6-bit signed holds S+D in -8..22 and S-D in -7..23 without overflow.
    logic signed [5:0] s_ext;
    logic signed [5:0] d_ext;
    logic signed [5:0] sum;
    logic signed [5:0] diff;
    logic signed [5:0] a_full;
    logic signed [5:0] b_full;

    always_comb begin
        s_ext  = signed'({2'b00, s});
        d_ext  = signed'({{2{d[RESW-1]}}, d});
        sum    = s_ext + d_ext;
        diff   = s_ext - d_ext;
        a_full = sum >>> 1;
        b_full = diff >>> 1;
        a      = a_full[OPW-1:0];
        b      = b_full[OPW-1:0];
        // Upper bits nonzero means the value is negative or above 7.
        arith_err = (s[0] != d[0])
                  || (a_full[5:OPW] != '0)
                  || (b_full[5:OPW] != '0);
    end

endmodule

// File: rtl/alu_result_decoder.sv
// alu_result_decoder
// Reassembles four-word ALU result frames (ADD, SUB, AND, OR) and recovers
// operands A and B, flagging inconsistent frames.
// Build macro: ALU_RESULT_LOGIC_CHECK_EN -- when defined, the AND and OR
// words are also checked against the recovered operands.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  synchronous active-high reset
//   in_valid   in  1  y_in valid this cycle
//   y_in       in  4  result word
//   resync     in  1  restart frame at ADD (y_in taken as ADD if in_valid)
//   a_out      out 3  recovered operand A (held between frames)
//   b_out      out 3  recovered operand B (held between frames)
//   out_valid  out 1  one-cycle pulse per completed frame
//   err        out 1  frame inconsistency, qualified by out_valid
//   err_sticky out 1  set by any err pulse, cleared by reset only
//   phase      out 2  expected type of next word
module alu_result_decoder
    import alu_frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] y_in,
    input  logic       resync,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    output logic       out_valid,
    output logic       err,
    output logic       err_sticky,
    output logic [1:0] phase
);

    phase_t          phase_q;
    phase_t          phase_d;
    logic [RESW-1:0] s_q;
    logic [RESW-1:0] d_q;
`ifdef ALU_RESULT_LOGIC_CHECK_EN
    logic [RESW-1:0] and_q;
`endif

    logic [OPW-1:0]  solved_a;
    logic [OPW-1:0]  solved_b;
    logic            arith_err;
    logic            frame_err;

    operand_solver u_solver (
        .s         (s_q),
        .d         (d_q),
        .a         (solved_a),
        .b         (solved_b),
        .arith_err (arith_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_ADD;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (resync) begin
            phase_d = in_valid ? PH_SUB : PH_ADD;
        end else if (in_valid) begin
            phase_d = phase_next(phase_q);
        end
    end

    // S and D are already registered when the OR word arrives, so the
    // solver output is final in the OR-phase cycle.
    always_comb begin
`ifdef ALU_RESULT_LOGIC_CHECK_EN
        frame_err = arith_err
                  || (and_q != {1'b0, solved_a & solved_b})
                  || (y_in  != {1'b0, solved_a | solved_b});
`else
        frame_err = arith_err;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q        <= '0;
            d_q        <= '0;
`ifdef ALU_RESULT_LOGIC_CHECK_EN
            and_q      <= '0;
`endif
            a_out      <= '0;
            b_out      <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (resync) begin
                if (in_valid) begin
                    s_q <= y_in;
                end
            end else if (in_valid) begin
                case (phase_q)
                    PH_ADD: s_q <= y_in;
                    PH_SUB: d_q <= y_in;
                    PH_AND: begin
`ifdef ALU_RESULT_LOGIC_CHECK_EN
                        and_q <= y_in;
`endif
                    end
                    PH_OR: begin
                        a_out     <= solved_a;
                        b_out     <= solved_b;
                        err       <= frame_err;
                        out_valid <= 1'b1;
                        if (frame_err) begin
                            err_sticky <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_alu_result_decoder.sv
// tb_alu_result_decoder
// Directed self-checking bench for alu_result_decoder. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point.
// Honours ALU_RESULT_LOGIC_CHECK_EN for the logic-check frame.
module tb_alu_result_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] y_in;
    logic       resync;
    logic [2:0] a_out;
    logic [2:0] b_out;
    logic       out_valid;
    logic       err;
    logic       err_sticky;
    logic [1:0] phase;

    int n_checks = 0;
    int n_passed = 0;

    alu_result_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .y_in       (y_in),
        .resync     (resync),
        .a_out      (a_out),
        .b_out      (b_out),
        .out_valid  (out_valid),
        .err        (err),
        .err_sticky (err_sticky),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic rs, input logic [3:0] w);
        in_valid = v;
        resync   = rs;
        y_in     = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        resync   = 1'b0;
        y_in     = 4'h0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [3:0] w0, input logic [3:0] w1,
                         input logic [3:0] w2, input logic [3:0] w3);
        step(1'b1, 1'b0, w0);
        step(1'b1, 1'b0, w1);
        step(1'b1, 1'b0, w2);
        step(1'b1, 1'b0, w3);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        resync   = 1'b1;
        y_in     = 4'hF;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 4'hF);
        reset = 1'b0;
        chk("rst_phase", 8'(phase), 8'd0);
        chk("rst_ov", 8'(out_valid), 8'd0);
        chk("rst_a", 8'(a_out), 8'd0);
        chk("rst_b", 8'(b_out), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_sticky", 8'(err_sticky), 8'd0);

        // A=5, B=3
        step(1'b1, 1'b0, 4'b1000);
        chk("ph_after_add", 8'(phase), 8'd1);
        step(1'b1, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b1111);
        chk("gap_phase", 8'(phase), 8'd2);
        step(1'b1, 1'b0, 4'b0001);
        chk("ov_before_or", 8'(out_valid), 8'd0);
        step(1'b1, 1'b0, 4'b0111);
        chk("f1_ov", 8'(out_valid), 8'd1);
        chk("f1_a", 8'(a_out), 8'd5);
        chk("f1_b", 8'(b_out), 8'd3);
        chk("f1_err", 8'(err), 8'd0);
        chk("f1_phase_wrap", 8'(phase), 8'd0);
        step(1'b0, 1'b0, 4'h0);
        chk("f1_ov_pulse", 8'(out_valid), 8'd0);
        chk("f1_a_hold", 8'(a_out), 8'd5);

        // A=2, B=6 (negative D)
        frame(4'b1000, 4'b1100, 4'b0010, 4'b0110);
        chk("f2_ov", 8'(out_valid), 8'd1);
        chk("f2_a", 8'(a_out), 8'd2);
        chk("f2_b", 8'(b_out), 8'd6);
        chk("f2_err", 8'(err), 8'd0);
        chk("f2_sticky", 8'(err_sticky), 8'd0);

        // A=0, B=7 (D=-7 boundary)
        frame(4'b0111, 4'b1001, 4'b0000, 4'b0111);
        chk("f3_a", 8'(a_out), 8'd0);
        chk("f3_b", 8'(b_out), 8'd7);
        chk("f3_err", 8'(err), 8'd0);

        // parity mismatch
        frame(4'b0111, 4'b0010, 4'b0000, 4'b0000);
        chk("par_ov", 8'(out_valid), 8'd1);
        chk("par_err", 8'(err), 8'd1);
        chk("par_sticky", 8'(err_sticky), 8'd1);

        // clean frame afterwards: err drops, sticky stays
        frame(4'b1000, 4'b0010, 4'b0001, 4'b0111);
        chk("clean_err", 8'(err), 8'd0);
        chk("clean_sticky", 8'(err_sticky), 8'd1);
        chk("clean_a", 8'(a_out), 8'd5);

        // S=0, D=2: parity fine, B=-1 out of range
        frame(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        chk("range_err", 8'(err), 8'd1);

        // reset after two words
        step(1'b1, 1'b0, 4'b1000);
        step(1'b1, 1'b0, 4'b0010);
        reset = 1'b1;
        step(1'b1, 1'b0, 4'b0001);
        reset = 1'b0;
        chk("mrst_phase", 8'(phase), 8'd0);
        chk("mrst_ov", 8'(out_valid), 8'd0);
        chk("mrst_a", 8'(a_out), 8'd0);
        chk("mrst_sticky", 8'(err_sticky), 8'd0);
        step(1'b1, 1'b0, 4'b1000);
        step(1'b1, 1'b0, 4'b0010);
        step(1'b1, 1'b0, 4'b0001);
        chk("mrst_no_ov", 8'(out_valid), 8'd0);
        step(1'b1, 1'b0, 4'b0111);
        chk("mrst_ov_done", 8'(out_valid), 8'd1);
        chk("mrst_a_done", 8'(a_out), 8'd5);
        chk("mrst_b_done", 8'(b_out), 8'd3);

        // wrong AND word
        frame(4'b1000, 4'b0010, 4'b0011, 4'b0111);
        chk("lc_a", 8'(a_out), 8'd5);
        chk("lc_b", 8'(b_out), 8'd3);
`ifdef ALU_RESULT_LOGIC_CHECK_EN
        chk("lc_err", 8'(err), 8'd1);
`else
        chk("lc_err", 8'(err), 8'd0);
`endif

        // stray word, then resync carrying the ADD word, gaps mid-frame
        step(1'b1, 1'b0, 4'b0100);
        chk("stray_phase", 8'(phase), 8'd1);
        step(1'b1, 1'b1, 4'b1000);
        chk("rs_phase", 8'(phase), 8'd1);
        step(1'b1, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b1111);
        chk("rs_gap_ov", 8'(out_valid), 8'd0);
        step(1'b1, 1'b0, 4'b0111);
        chk("rs_ov", 8'(out_valid), 8'd1);
        chk("rs_a", 8'(a_out), 8'd5);
        chk("rs_b", 8'(b_out), 8'd3);
        chk("rs_err", 8'(err), 8'd0);

        // resync without valid word returns to ADD
        step(1'b1, 1'b0, 4'b1000);
        step(1'b0, 1'b1, 4'b0000);
        chk("rs_idle_phase", 8'(phase), 8'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
